// File: rtl/pwm_decoder_pkg.sv
// pwm_decoder_pkg
//   Shared definitions for the PWM decoder slice:
//   - state_e       : decoder FSM states (3-bit encoding)
//   - CTR_LEN_DEFAULT: default measurement counter length
//   - meas_width()  : measurement width W = CTR_LEN+1
//   - default_timeout(): default edge-less cycle budget before a stuck report
package pwm_decoder_pkg;

  localparam int unsigned CTR_LEN_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_STUCK = 3'd4
  } state_e;

  function automatic int unsigned meas_width(input int unsigned ctr_len);
    return ctr_len + 1;
  endfunction

  // 2**CTR_LEN + 2: one full generator period plus slack for the
  // synchronizer, while staying below 2**(CTR_LEN+1).
  function automatic int unsigned default_timeout(input int unsigned ctr_len);
    return (32'd1 << ctr_len) + 32'd2;
  endfunction

endpackage

// File: rtl/pwm_decoder_sync_edge.sv
// sync_edge
//   Input synchronizer and edge detector for the PWM decoder.
//   Ports:
//     clk    in  1  system clock
//     rst    in  1  synchronous, active-high reset
//     pwm_in in  1  asynchronous PWM input
//     s      out 1  synchronized line level
//     rise   out 1  s went 0->1 this cycle
//     fall   out 1  s went 1->0 this cycle
//     filled out 1  synchronizer chain holds real samples (s is meaningful)
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall,
  output logic filled
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // fill_q tracks how far real samples have propagated after reset: bit
  // SYNC_STAGES-1 marks s as valid, bit SYNC_STAGES marks prev_q as valid.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   edge_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign filled  = fill_q[SYNC_STAGES-1];
  // Suppress the false edge the reset value of prev_q would otherwise
  // produce against a line that is already high.
  assign edge_ok = fill_q[SYNC_STAGES];
  assign rise    = edge_ok &  s & ~prev_q;
  assign fall    = edge_ok & ~s &  prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder
//   Measures an incoming PWM waveform in clk cycles. Reports high time and
//   period once per complete cycle (at each closing rise) and reports a
//   stuck-high / stuck-low line after TIMEOUT cycles without an edge.
//   Ports:
//     clk         in  1  system clock
//     rst         in  1  synchronous, active-high reset
//     pwm_in      in  1  asynchronous PWM input
//     valid       out 1  one-cycle strobe; report outputs updated this cycle
//     high_time   out W  cycles from rise detect to fall detect
//     period      out W  cycles between consecutive rise detects
//     stuck       out 1  report is a timeout, not a measurement
//     stuck_level out 1  line level at timeout (meaningful when stuck=1)
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int unsigned CTR_LEN     = CTR_LEN_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = default_timeout(CTR_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic             valid,
  output logic [CTR_LEN:0] high_time,
  output logic [CTR_LEN:0] period,
  output logic             stuck,
  output logic             stuck_level
);

  localparam int unsigned  W   = meas_width(CTR_LEN);
  localparam logic [W-1:0] TMO = W'(TIMEOUT);
  localparam logic [W-1:0] ONE = W'(1);

  logic s, rise, fall, filled;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall),
    .filled (filled)
  );

  state_e       state_q, state_d;
  logic [W-1:0] per_cnt_q, per_cnt_d;
  logic [W-1:0] idle_cnt_q, idle_cnt_d;
  logic [W-1:0] hi_lat_q, hi_lat_d;
  logic         valid_q, valid_d;
  logic [W-1:0] high_time_q, high_time_d;
  logic [W-1:0] period_q, period_d;
  logic         stuck_q, stuck_d;
  logic         stuck_lvl_q, stuck_lvl_d;

  logic any_edge;
  logic timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      per_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      hi_lat_q    <= '0;
      valid_q     <= 1'b0;
      high_time_q <= '0;
      period_q    <= '0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      hi_lat_q    <= hi_lat_d;
      valid_q     <= valid_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    hi_lat_d    = hi_lat_q;
    valid_d     = 1'b0;
    high_time_d = high_time_q;
    period_d    = period_q;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;

    any_edge = rise | fall;

    // Counts are "cycles since the edge": the edge cycle itself is 0, the
    // next is 1. The idle count freezes in STUCK so it cannot overflow.
    if (any_edge) begin
      idle_cnt_d = ONE;
    end else if (state_q != ST_STUCK) begin
      idle_cnt_d = idle_cnt_q + ONE;
    end

    // The period cap keeps per_cnt within W bits when high and low phases
    // are each shorter than TIMEOUT but their sum is not. An edge on the
    // same cycle always wins over the timeout.
    timeout = (state_q != ST_STUCK) && !any_edge &&
              ((idle_cnt_q == TMO) || (per_cnt_q == TMO));

    if (timeout) begin
      state_d     = ST_STUCK;
      per_cnt_d   = '0;
      valid_d     = 1'b1;
      high_time_d = '0;
      period_d    = '0;
      stuck_d     = 1'b1;
      stuck_lvl_d = s;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Arming restarts the idle count so a low line times out exactly
          // TIMEOUT cycles after ARMED is entered.
          if (filled && !s) begin
            state_d    = ST_ARMED;
            idle_cnt_d = ONE;
          end
        end
        ST_ARMED: begin
          if (rise) begin
            state_d   = ST_HIGH;
            per_cnt_d = ONE;
          end
        end
        ST_HIGH: begin
          per_cnt_d = per_cnt_q + ONE;
          if (fall) begin
            state_d  = ST_LOW;
            hi_lat_d = per_cnt_q;
          end
        end
        ST_LOW: begin
          per_cnt_d = per_cnt_q + ONE;
          if (rise) begin
            state_d     = ST_HIGH;
            per_cnt_d   = ONE;
            valid_d     = 1'b1;
            high_time_d = hi_lat_q;
            period_d    = per_cnt_q;
            stuck_d     = 1'b0;
            stuck_lvl_d = 1'b0;
          end
        end
        ST_STUCK: begin
          if (rise) begin
            state_d   = ST_HIGH;
            per_cnt_d = ONE;
          end else if (fall) begin
            state_d = ST_ARMED;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          per_cnt_d = '0;
        end
      endcase
    end
  end

  assign valid       = valid_q;
  assign high_time   = high_time_q;
  assign period      = period_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
//   Drives a behavioural PWM waveform (8-cycle period, programmable compare)
//   into pwm_decoder. Each driven rise that closes a measured cycle pushes
//   the expected report (period, high time, arrival cycle) into a queue;
//   valid strobes from the DUT pop and compare against it.
module tb_pwm_decoder;

  localparam int unsigned CTR_LEN     = 3;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 10;
  localparam int          W           = CTR_LEN + 1;
  // Pin driven after edge k -> valid sampled after edge k+LAT.
  localparam int          LAT         = SYNC_STAGES + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic         valid;
  logic [W-1:0] high_time;
  logic [W-1:0] period;
  logic         stuck;
  logic         stuck_level;

  pwm_decoder #(
    .CTR_LEN     (CTR_LEN),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .valid       (valid),
    .high_time   (high_time),
    .period      (period),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
    int stk;
    int lvl;
    int at;
  } exp_t;

  exp_t sb[$];

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int last_rise = 0;
  int last_fall = 0;
  int rst_rel   = 0;
  bit armed     = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (valid !== 1'b0) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", valid, 0);
      end else begin
        e = sb.pop_front();
        check_eq("latency", cyc, e.at);
        check_eq("period", period, e.per);
        check_eq("high_time", high_time, e.hi);
        check_eq("stuck", stuck, e.stk);
        if (e.stk != 0) check_eq("stuck_level", stuck_level, e.lvl);
      end
    end else if (sb.size() != 0 && cyc > sb[0].at) begin
      check_eq("missing_valid", valid, 1);
      e = sb.pop_front();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic push_stuck(input int lvl, input int at);
    exp_t e;
    e.per = 0;
    e.hi  = 0;
    e.stk = 1;
    e.lvl = lvl;
    e.at  = at;
    sb.push_back(e);
  endtask

  // The first rise after reset/timeout only arms the decoder; every later
  // rise closes a cycle measured from the drive times.
  task automatic drive(input logic v);
    exp_t e;
    if (v && !pwm_in) begin
      if (armed) begin
        e.per = cyc - last_rise;
        e.hi  = last_fall - last_rise;
        e.stk = 0;
        e.lvl = 0;
        e.at  = cyc + LAT;
        sb.push_back(e);
      end
      armed     = 1'b1;
      last_rise = cyc;
    end else if (!v && pwm_in) begin
      last_fall = cyc;
    end
    pwm_in = v;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_valid"}, valid, 0);
    check_eq({pfx, "_high_time"}, high_time, 0);
    check_eq({pfx, "_period"}, period, 0);
    check_eq({pfx, "_stuck"}, stuck, 0);
    check_eq({pfx, "_stuck_level"}, stuck_level, 0);
  endtask

  task automatic do_reset(input logic level);
    armed = 1'b0;
    rst   = 1'b1;
    drive(level);
    repeat (3) step();
    rst     = 1'b0;
    armed   = 1'b0;
    rst_rel = cyc;
  endtask

  // Generator: counter 0..7, output high while counter < cmp. A one-cycle
  // reset is injected at counter value 4 of period rst_p (inside HIGH).
  task automatic pwm_run(input int cmp, input int periods, input int rst_p);
    for (int p = 0; p < periods; p++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        drive(c < cmp);
        if (p == rst_p && c == 4) begin
          rst = 1'b1;
          step();
          check_zero_outputs("midrst");
          rst   = 1'b0;
          armed = 1'b0;
        end
      end
    end
  endtask

  initial begin
    // Reset state, then normal loop-back measurements.
    do_reset(1'b0);
    check_zero_outputs("reset");
    repeat (4) begin
      step();
      drive(1'b0);
    end
    pwm_run(3, 6, -1);
    pwm_run(7, 5, 1);
    pwm_run(1, 4, -1);
    repeat (2) step();

    // Line held low from reset: one stuck report TIMEOUT cycles after arming.
    do_reset(1'b0);
    push_stuck(0, rst_rel + int'(TIMEOUT) + 3);
    repeat (4 * TIMEOUT) step();

    // Rise detected on the cycle the idle count reaches TIMEOUT.
    do_reset(1'b0);
    while (cyc < rst_rel + int'(TIMEOUT) - 1) step();
    pwm_run(3, 4, -1);
    repeat (2) step();

    // Line held high through reset, then released.
    do_reset(1'b1);
    push_stuck(1, rst_rel + int'(TIMEOUT) + 1);
    repeat (3 * TIMEOUT) step();
    repeat (4) begin
      step();
      drive(1'b0);
    end
    pwm_run(3, 4, -1);
    repeat (4) step();

    check_eq("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
